// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Parametrised multi-port register file. Two write ports (port 1
//             has priority), NUM_RD combinational read ports, a per-entry busy
//             scoreboard and a sequenced bulk-clear engine that zeroes one
//             entry per cycle.
//  Options  : REGFILE_BYPASS_EN - when defined, read ports forward same-cycle
//             write data (and the resulting busy state) combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic [NUM_RD-1:0]          rbusy,
   input  logic                       set_busy,
   input  logic [ADDR_W-1:0]          set_addr,
   input  logic                       clr_req,
   output logic                       clr_busy
);

   localparam int              c_DEPTH    = 2 ** ADDR_W;
   localparam bit              c_ZERO_EN  = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   w_idx_nxt;
   logic [DATA_W-1:0]   r_mem [c_DEPTH];
   logic [c_DEPTH-1:0]  r_busy;
   logic [c_DEPTH-1:0]  w_busy_nxt;

   logic                w_accept;
   logic                w_wr0;
   logic                w_wr1;
   logic                w_set;

   // Writes and set_busy only take effect while idle and not starting a clear;
   // entry 0 is hard-wired when ZERO_REG is enabled.
   assign w_accept = (r_state == ST_IDLE) && !clr_req;
   assign w_wr0    = we0      && w_accept && !(c_ZERO_EN && (waddr0   == '0));
   assign w_wr1    = we1      && w_accept && !(c_ZERO_EN && (waddr1   == '0));
   assign w_set    = set_busy && w_accept && !(c_ZERO_EN && (set_addr == '0));

   assign clr_busy = (r_state == ST_CLEAR);

   // FSM next-state and clear-index sequencing
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == c_LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // FSM state and clear-index registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Scoreboard update: writes retire the producer, a same-edge set wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr0) w_busy_nxt[waddr0]   = 1'b0;
      if (w_wr1) w_busy_nxt[waddr1]   = 1'b0;
      if (w_set) w_busy_nxt[set_addr] = 1'b1;
   end

   // Busy vector: wiped on the clear request edge, frozen during CLEAR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else if (r_state == ST_IDLE) begin
         if (clr_req) begin
            r_busy <= '0;
         end else begin
            r_busy <= w_busy_nxt;
         end
      end
   end

   // Storage array: one entry zeroed per cycle in CLEAR, otherwise two
   // write ports with port 1 applied last so it wins on an address clash
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ST_CLEAR) begin
         r_mem[r_idx] <= '0;
      end else begin
         if (w_wr0) r_mem[waddr0] <= wdata0;
         if (w_wr1) r_mem[waddr1] <= wdata1;
      end
   end

   // Combinational read ports
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rb;

      assign w_ra = raddr[gi*ADDR_W +: ADDR_W];

      // Stored value, optional same-cycle forwarding, then the entry-0 rule
      always_comb begin
         w_rd = r_mem[w_ra];
         w_rb = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
         if (w_wr1 && (waddr1 == w_ra)) begin
            w_rd = wdata1;
            w_rb = w_set && (set_addr == w_ra);
         end else if (w_wr0 && (waddr0 == w_ra)) begin
            w_rd = wdata0;
            w_rb = w_set && (set_addr == w_ra);
         end
`else
`endif
         if (c_ZERO_EN && (w_ra == '0)) begin
            w_rd = '0;
            w_rb = 1'b0;
         end
      end

      assign rdata[gi*DATA_W +: DATA_W] = w_rd;
      assign rbusy[gi]                  = w_rb;
   end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the CPU datapath. It provides a configurable width, depth and read-port count, two write ports with fixed priority, and a per-register busy scoreboard for tracking in-flight producers. A sequenced bulk-clear engine zeroes the whole array one entry per cycle. It replaces the fixed 32×32, 1-write/2-read register file in the decode/writeback stages.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never busy
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0
- we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1, priority over port 0
- raddr  input  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rdata  output  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- rbusy  output  NUM_RD  busy bit of the entry addressed by each read port
- set_busy / set_addr  input  1 / ADDR_W  mark entry as having a pending producer
- clr_req  input  1  request bulk clear of all entries and busy bits
- clr_busy  output  1  high while the clear sequence runs

## Operation
- Storage: DEPTH×DATA_W array plus a DEPTH-bit busy vector.
- Reads are combinational:
  - rdata[i] = array[raddr[i]].
  - rdata[i] = 0 when ZERO_REG=1 and raddr[i]=0.
  - rbusy[i] = busy[raddr[i]].
- Writes:
  - Port p writes on the edge when we_p=1, the FSM is in IDLE, clr_req=0, and the target is not entry 0 with ZERO_REG=1.
  - If both ports target the same address, port 1 data is stored.
- Scoreboard:
  - set_busy sets busy[set_addr].
  - Any performed write clears busy[waddr].
  - If set_busy and a write hit the same address on the same edge, set wins (busy=1).
  - set_busy to entry 0 with ZERO_REG=1 is ignored.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on an edge with clr_req=1. On that edge: the index counter is set to 0, the whole busy vector is cleared, and writes and set_busy in that cycle are dropped.
  - In CLEAR, each edge writes 0 to array[index] and increments the index.
  - The edge with index=DEPTH-1 returns the FSM to IDLE.
  - In CLEAR, we0, we1, set_busy and clr_req are ignored. Reads remain live and return partially cleared contents.
  - clr_busy = (state==CLEAR).
- Reset: all array entries 0, busy vector 0, FSM IDLE, index 0. Reset asserted mid-clear aborts immediately to IDLE with everything zeroed.

## Timing
- Read latency 0 cycles (combinational from raddr and state).
- Write-to-read visibility is 1 cycle: data written on edge N is readable after edge N.
- A set_busy at edge N is seen on rbusy after edge N.
- Clear occupies exactly DEPTH cycles: clr_busy is high from the edge after the request for DEPTH cycles. The first new write is accepted at edge request+DEPTH+1.
- Outputs during and after reset: rdata all 0, rbusy 0, clr_busy 0.

## Configuration
- REGFILE_BYPASS_EN defined: each read port forwards write data combinationally when a performed write targets raddr[i] in the same cycle.
  - Port 1 data has priority over port 0.
  - rbusy[i] reads 0 for that address unless set_busy also targets it.
  - The entry-0 rule with ZERO_REG=1 still forces 0.
- Not defined: reads return the stored (pre-edge) value; there is no forwarding path.

## Test plan
- Reset, then read all addresses on both ports: rdata=0, rbusy=0, clr_busy=0.
- Write 0xDEADBEEF to entry 5 via port 0, then read the next cycle: rdata=0xDEADBEEF. Write 0x1234 to entry 0: entry 0 still reads 0.
- Same cycle, port 0 writes 0x11 and port 1 writes 0x22 to entry 7: entry 7 reads 0x22.
- set_busy on entry 3: rbusy=1. Write entry 3: rbusy=0. Set and write entry 3 on the same edge: rbusy=1.
- Same-cycle write of 0xABCD and read of entry 9:
  - With REGFILE_BYPASS_EN: rdata=0xABCD in that cycle.
  - Without: rdata holds the old value, and 0xABCD appears the next cycle.
- Fill all entries, assert clr_req with a simultaneous write:
  - clr_busy is high for exactly 32 cycles (default parameters) and the write is dropped.
  - Writes during CLEAR are ignored; every entry reads 0 afterwards.
  - Asserting rst at clear cycle 10 returns the FSM to IDLE with everything zero.
